// File: rtl/ysyx_22041752_icache_nway.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_icache_nway
// Blocking N-way set-associative instruction cache between the IFU and the
// memory arbiter. Lines are refilled by a multi-beat burst. The victim is the
// lowest invalid way of the set, or else the set's round-robin pointer.
// fence.i invalidates the whole cache by walking the sets, one set per cycle.
// Tags, data and valid bits are held in flop arrays.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop the in-flight fetch response
//   fence_i               pulse: invalidate every line
//   inst_en, inst_addr    fetch request (hold while cache_miss is high)
//   inst_rdata/inst_valid fetched instruction and its one-cycle strobe
//   cache_miss            busy: the request on inst_en is not taken
//   mem_req/mem_ready     refill request handshake, mem_addr line-aligned
//   mem_rdata/mem_valid   refill beats, in ascending address order
// ----------------------------------------------------------------------------
module ysyx_22041752_icache_nway #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int NWAYS      = 4,
    parameter int NSETS      = 64,
    parameter int LINE_BYTES = 16,
    parameter int MEM_W      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              fence_i,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [INST_W-1:0] inst_rdata,
    output logic              inst_valid,
    output logic              cache_miss,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [MEM_W-1:0]  mem_rdata,
    input  logic              mem_valid
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / MEM_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int ISH    = $clog2(INST_W / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP, S_INV
    } state_t;

    // Storage
    logic [NSETS-1:0]  valid_q [NWAYS];
    logic [TAG_W-1:0]  tag_q   [NWAYS][NSETS];
    logic [LINE_W-1:0] data_q  [NWAYS][NSETS];
    logic [WAY_W-1:0]  rr_q    [NSETS];

    // Control flops
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  walk_q, walk_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d;
    logic              flush_pend_q, flush_pend_d;
    logic              fence_pend_q, fence_pend_d;
    logic              inst_valid_q, inst_valid_d;
    logic              cache_miss_q, cache_miss_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] inst_rdata_q, inst_rdata_d;

    // Combinational helpers
    logic [IDX_W-1:0]  lk_idx_s, rf_idx_s;
    logic [TAG_W-1:0]  lk_tag_s, rf_tag_s;
    logic [NWAYS-1:0]  hit_vec_s;
    logic              lk_hit_s;
    logic [INST_W-1:0] lk_word_s;
    logic [WAY_W-1:0]  vic_way_s;
    logic              all_valid_s;
    logic [LINE_W-1:0] fill_line_s;
    logic              wr_en_s, inv_en_s;

    function automatic logic [INST_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        logic [OFF_W-1:0] w;
        w = off >> ISH;
        return line[w*INST_W +: INST_W];
    endfunction

    assign lk_idx_s = inst_addr[OFF_W +: IDX_W];
    assign lk_tag_s = inst_addr[ADDR_W-1 -: TAG_W];
    assign rf_idx_s = req_addr_q[OFF_W +: IDX_W];
    assign rf_tag_s = req_addr_q[ADDR_W-1 -: TAG_W];

    // The tag compare runs on inst_addr at the accepting edge, so the result is
    // already registered when the LOOKUP cycle begins.
    always_comb begin
        lk_hit_s  = 1'b0;
        lk_word_s = {INST_W{1'b0}};
        for (int w = NWAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = valid_q[w][lk_idx_s] && (tag_q[w][lk_idx_s] == lk_tag_s);
            lk_word_s    = hit_vec_s[w] ? pick_word(data_q[w][lk_idx_s], inst_addr[OFF_W-1:0])
                                        : lk_word_s;
            lk_hit_s     = lk_hit_s | hit_vec_s[w];
        end
    end

    // Victim choice: the descending scan leaves the lowest invalid way, else the RR pointer.
    always_comb begin
        all_valid_s = 1'b1;
        vic_way_s   = rr_q[rf_idx_s];
        for (int w = NWAYS - 1; w >= 0; w--) begin
            vic_way_s   = valid_q[w][rf_idx_s] ? vic_way_s : WAY_W'(w);
            all_valid_s = all_valid_s & valid_q[w][rf_idx_s];
        end
        fill_line_s = line_buf_q;
        fill_line_s[beat_q*MEM_W +: MEM_W] = mem_rdata;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        beat_d       = beat_q;
        walk_d       = walk_q;
        line_buf_d   = line_buf_q;
        flush_pend_d = flush_pend_q;
        fence_pend_d = fence_pend_q;
        inst_valid_d = 1'b0;
        cache_miss_d = cache_miss_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_rdata_d = inst_rdata_q;
        wr_en_s      = 1'b0;
        inv_en_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fence_i) begin
                    state_d      = S_INV;
                    walk_d       = {IDX_W{1'b0}};
                    cache_miss_d = 1'b1;
                end else if (inst_en) begin
                    req_addr_d   = inst_addr;
                    state_d      = S_LOOKUP;
                    inst_valid_d = lk_hit_s;
                    inst_rdata_d = lk_hit_s ? lk_word_s : inst_rdata_q;
                    cache_miss_d = ~lk_hit_s;
                end else begin
                    cache_miss_d = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (flush) begin
                    state_d      = S_IDLE;
                    cache_miss_d = 1'b0;
                end else if (fence_i) begin
                    state_d      = S_INV;
                    walk_d       = {IDX_W{1'b0}};
                    cache_miss_d = 1'b1;
                end else if (cache_miss_q) begin
                    state_d      = S_MISS_REQ;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = {rf_tag_s, rf_idx_s, {OFF_W{1'b0}}};
                    cache_miss_d = 1'b1;
                    flush_pend_d = 1'b0;
                    fence_pend_d = 1'b0;
                end else if (inst_en) begin
                    req_addr_d   = inst_addr;
                    state_d      = S_LOOKUP;
                    inst_valid_d = lk_hit_s;
                    inst_rdata_d = lk_hit_s ? lk_word_s : inst_rdata_q;
                    cache_miss_d = ~lk_hit_s;
                end else begin
                    state_d      = S_IDLE;
                    cache_miss_d = 1'b0;
                end
            end
            S_MISS_REQ: begin
                cache_miss_d = 1'b1;
                flush_pend_d = flush_pend_q | flush;
                fence_pend_d = fence_pend_q | fence_i;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    beat_d    = {BEAT_W{1'b0}};
                    state_d   = S_REFILL;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_REFILL: begin
                cache_miss_d = 1'b1;
                flush_pend_d = flush_pend_q | flush;
                fence_pend_d = fence_pend_q | fence_i;
                if (mem_valid && (beat_q == BEAT_W'(BEATS - 1))) begin
                    // Last beat: install the line and answer from the assembled copy.
                    wr_en_s      = 1'b1;
                    state_d      = S_RESP;
                    inst_valid_d = ~(flush_pend_q | flush);
                    inst_rdata_d = pick_word(fill_line_s, req_addr_q[OFF_W-1:0]);
                    cache_miss_d = 1'b0;
                    beat_d       = {BEAT_W{1'b0}};
                end else if (mem_valid) begin
                    line_buf_d = fill_line_s;
                    beat_d     = beat_q + BEAT_W'(1);
                end else begin
                    beat_d = beat_q;
                end
            end
            S_RESP: begin
                flush_pend_d = 1'b0;
                if (fence_pend_q || fence_i) begin
                    state_d      = S_INV;
                    walk_d       = {IDX_W{1'b0}};
                    fence_pend_d = 1'b0;
                    cache_miss_d = 1'b1;
                end else begin
                    state_d      = S_IDLE;
                    cache_miss_d = 1'b0;
                end
            end
            S_INV: begin
                inv_en_s = 1'b1;
                if (fence_i) begin
                    walk_d       = {IDX_W{1'b0}};
                    cache_miss_d = 1'b1;
                end else if (walk_q == IDX_W'(NSETS - 1)) begin
                    walk_d       = {IDX_W{1'b0}};
                    state_d      = S_IDLE;
                    cache_miss_d = 1'b0;
                end else begin
                    walk_d       = walk_q + IDX_W'(1);
                    cache_miss_d = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                cache_miss_d = 1'b0;
                mem_req_d    = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_addr_q   <= {ADDR_W{1'b0}};
            beat_q       <= {BEAT_W{1'b0}};
            walk_q       <= {IDX_W{1'b0}};
            line_buf_q   <= {LINE_W{1'b0}};
            flush_pend_q <= 1'b0;
            fence_pend_q <= 1'b0;
            inst_valid_q <= 1'b0;
            cache_miss_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            inst_rdata_q <= {INST_W{1'b0}};
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            beat_q       <= beat_d;
            walk_q       <= walk_d;
            line_buf_q   <= line_buf_d;
            flush_pend_q <= flush_pend_d;
            fence_pend_q <= fence_pend_d;
            inst_valid_q <= inst_valid_d;
            cache_miss_q <= cache_miss_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_rdata_q <= inst_rdata_d;
        end
    end

    // Valid bits and round-robin pointers; the pointer moves only when a valid line is evicted.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NWAYS; w++) valid_q[w] <= {NSETS{1'b0}};
            for (int s = 0; s < NSETS; s++) rr_q[s] <= {WAY_W{1'b0}};
        end else if (inv_en_s) begin
            for (int w = 0; w < NWAYS; w++) valid_q[w][walk_q] <= 1'b0;
        end else if (wr_en_s) begin
            valid_q[vic_way_s][rf_idx_s] <= 1'b1;
            if (all_valid_s) begin
                rr_q[rf_idx_s] <= (rr_q[rf_idx_s] == WAY_W'(NWAYS - 1)) ? WAY_W'(0)
                                                                        : rr_q[rf_idx_s] + WAY_W'(1);
            end
        end
    end

    // Tag and data arrays need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_q[vic_way_s][rf_idx_s]  <= rf_tag_s;
            data_q[vic_way_s][rf_idx_s] <= fill_line_s;
        end
    end

    // A fence arriving with a request in IDLE/LOOKUP must hold that request off at once.
    assign cache_miss = cache_miss_q | (fence_i & ((state_q == S_IDLE) | (state_q == S_LOOKUP)));
    assign inst_valid = inst_valid_q & ~flush;
    assign inst_rdata = inst_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_ysyx_22041752_icache_nway.sv
module tb_ysyx_22041752_icache_nway;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        fence_i;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        cache_miss;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_valid;

    int n_checks;
    int n_fail;

    ysyx_22041752_icache_nway dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fence_i    (fence_i),
        .inst_en    (inst_en),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_valid (inst_valid),
        .cache_miss (cache_miss),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory content: every 32-bit word holds the inverse of its address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] line, input int b);
        logic [31:0] base;
        base = line + 32'(b * 8);
        return {word_at(base + 32'd4), word_at(base)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Full miss: request, refill handshake, two beats, response (optionally flushed).
    task automatic fetch_miss(input string tag, input logic [31:0] addr, input bit do_flush);
        logic [31:0] line;
        bit          seen;
        line      = addr & 32'hFFFF_FFF0;
        inst_en   = 1'b1;
        inst_addr = addr;
        step();
        check_val({tag, "_miss"}, {63'd0, cache_miss}, 64'd1);
        check_val({tag, "_novalid"}, {63'd0, inst_valid}, 64'd0);
        inst_en = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else step();
        end
        check_val({tag, "_memreq"}, {63'd0, seen}, 64'd1);
        if (!seen) return;
        check_val({tag, "_memaddr"}, {32'd0, mem_addr}, {32'd0, line});
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_val({tag, "_busy"}, {63'd0, cache_miss}, 64'd1);
        for (int b = 0; b < 2; b++) begin
            mem_valid = 1'b1;
            mem_rdata = beat_of(line, b);
            flush     = do_flush && (b == 1);
            step();
        end
        mem_valid = 1'b0;
        mem_rdata = 64'd0;
        flush     = 1'b0;
        check_val({tag, "_valid"}, {63'd0, inst_valid}, {63'd0, !do_flush});
        if (!do_flush) check_val({tag, "_data"}, {32'd0, inst_rdata}, {32'd0, word_at(addr)});
        step();
        check_val({tag, "_strobe"}, {63'd0, inst_valid}, 64'd0);
    endtask

    // Back-to-back hits: one response per cycle, no refill traffic.
    task automatic hit_run(input string tag, input logic [31:0] addrs [3], input int n);
        inst_en   = 1'b1;
        inst_addr = addrs[0];
        for (int i = 0; i < n; i++) begin
            step();
            check_val({tag, "_valid"}, {63'd0, inst_valid}, 64'd1);
            check_val({tag, "_data"}, {32'd0, inst_rdata}, {32'd0, word_at(addrs[i])});
            check_val({tag, "_nomiss"}, {62'd0, cache_miss, mem_req}, 64'd0);
            if (i + 1 < n) inst_addr = addrs[i + 1];
            else inst_en = 1'b0;
        end
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, {63'd0, inst_valid}, 64'd0);
        check_val({tag, "_miss"}, {63'd0, cache_miss}, 64'd0);
        check_val({tag, "_memreq"}, {63'd0, mem_req}, 64'd0);
        check_val({tag, "_memaddr"}, {32'd0, mem_addr}, 64'd0);
        check_val({tag, "_rdata"}, {32'd0, inst_rdata}, 64'd0);
    endtask

    initial begin
        int          cnt;
        bit          seen;
        logic [31:0] a3 [3];
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        fence_i   = 1'b0;
        inst_en   = 1'b0;
        inst_addr = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 64'd0;
        mem_valid = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        // T1 cold miss
        fetch_miss("t1", 32'h8000_0004, 1'b0);

        // T2 three consecutive hits in the same line
        a3 = '{32'h8000_0000, 32'h8000_0008, 32'h8000_000C};
        hit_run("t2", a3, 3);

        // T4 fence.i together with a request: request held, 64-cycle walk, then cold again
        fence_i   = 1'b1;
        inst_en   = 1'b1;
        inst_addr = 32'h8000_0000;
        #1;
        check_val("t4_hold", {63'd0, cache_miss}, 64'd1);
        step();
        fence_i = 1'b0;
        cnt     = 0;
        while (cache_miss && cnt < 200) begin
            cnt++;
            step();
        end
        check_val("t4_inv_cycles", 64'(cnt), 64'd64);
        fetch_miss("t4", 32'h8000_0000, 1'b0);

        // T3 five lines into set 0: the fifth evicts way0 (line 0)
        fetch_miss("t3_l1", 32'h8000_0400, 1'b0);
        fetch_miss("t3_l2", 32'h8000_0800, 1'b0);
        fetch_miss("t3_l3", 32'h8000_0C00, 1'b0);
        fetch_miss("t3_l4", 32'h8000_1004, 1'b0);
        a3 = '{32'h8000_1008, 32'h8000_0808, 32'h8000_0C0C};
        hit_run("t3_hits", a3, 3);
        fetch_miss("t3_l0", 32'h8000_000C, 1'b0);

        // T5 flush on the last refill beat: no response, but the line is installed
        fetch_miss("t5", 32'h8000_0100, 1'b1);
        a3 = '{32'h8000_0108, 32'h8000_0100, 32'h8000_0104};
        hit_run("t5_hit", a3, 1);

        // T6 reset in the middle of a refill
        inst_en   = 1'b1;
        inst_addr = 32'h8000_0204;
        step();
        inst_en = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (mem_req) seen = 1'b1;
            else step();
        end
        check_val("t6_memreq", {63'd0, seen}, 64'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = beat_of(32'h8000_0200, 0);
        step();
        mem_valid = 1'b0;
        mem_rdata = 64'd0;
        reset     = 1'b1;
        step();
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        step();
        fetch_miss("t6_l5", 32'h8000_0104, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
